// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Shared definitions for the intersection blocks. The upstream light
//   controller and the pedestrian signal agree on the vehicle light encoding
//   through this package, and the pedestrian FSM state encoding lives here so
//   that any observer (debug taps, the controller) decodes it the same way.
//
//   Contents:
//     light_t       vehicle light code, 2 bits (RED/GREEN/YELLOW/ILLEGAL)
//     LIGHT_*       the same codes as plain 2-bit constants for comparisons
//     ped_state_t   pedestrian FSM states (IDLE, WALK, FLASH)
//     is_red()      helper: true when a light code is steady red
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    RED     = 2'b00,
    GREEN   = 2'b01,
    YELLOW  = 2'b10,
    ILLEGAL = 2'b11
  } light_t;

  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_GREEN   = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b10;
  localparam logic [1:0] LIGHT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    PED_IDLE  = 2'b00,
    PED_WALK  = 2'b01,
    PED_FLASH = 2'b10
  } ped_state_t;

  function automatic logic is_red(input logic [1:0] code);
    return (code == LIGHT_RED);
  endfunction

endpackage

// File: rtl/pedestrian_signal.sv
// -----------------------------------------------------------------------------
// pedestrian_signal
//   Pedestrian crossing lamp controller slaved to a vehicle light controller.
//   A crossing is granted only on the cycle the vehicle light enters red
//   (red_entry) and only if a request is latched or being pressed. The
//   crossing is WALK for WALK_CYCLES cycles, then FLASH (dont_walk blinking,
//   starting lit) for FLASH_CYCLES cycles, then back to IDLE. Any non-red
//   light during a crossing aborts it. An illegal light code sets a sticky
//   fault that blocks all crossings until reset.
//
//   Parameters:
//     WALK_CYCLES   steady-walk cycles per crossing, 1..15
//     FLASH_CYCLES  flashing dont_walk cycles after walk, 1..15
//
//   Ports:
//     clk          in   clock, rising edge
//     reset        in   asynchronous active-high reset
//     light[1:0]   in   vehicle light code (00 red, 01 green, 10 yellow, 11 illegal)
//     ped_req      in   pedestrian button, level-sampled
//     walk         out  walk lamp (registered)
//     dont_walk    out  don't-walk lamp (registered)
//     req_pending  out  latched request awaiting a red entry
//     fault        out  sticky illegal-light-code flag
//     countdown    out  remaining crossing cycles (4 bits)
//
//   Build option:
//     PED_COUNTDOWN_EN  when defined, countdown reports remaining crossing
//                       cycles (saturating at 15); otherwise it is tied to 0
//                       and no countdown logic exists.
// -----------------------------------------------------------------------------
module pedestrian_signal
  import traffic_pkg::*;
#(
  parameter int WALK_CYCLES  = 3,
  parameter int FLASH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] light,
  input  logic       ped_req,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
  output logic       fault,
  output logic [3:0] countdown
);

  localparam logic [3:0] WALK_LOAD  = 4'(WALK_CYCLES - 1);
  localparam logic [3:0] FLASH_LOAD = 4'(FLASH_CYCLES - 1);

  ped_state_t state_q, state_d;
  logic [1:0] prev_light_q;
  logic [3:0] cnt_q, cnt_d;
  logic       walk_q, walk_d;
  logic       dont_walk_q, dont_walk_d;
  logic       req_pending_q, req_pending_d;
  logic       fault_q, fault_d;

  logic light_red;
  logic red_entry;

  assign light_red = is_red(light);
  // prev_light resets to red, so a red already present at reset release is
  // not mistaken for a fresh transition into red.
  assign red_entry = light_red && !is_red(prev_light_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= PED_IDLE;
      prev_light_q  <= LIGHT_RED;
      cnt_q         <= 4'd0;
      walk_q        <= 1'b0;
      dont_walk_q   <= 1'b1;
      req_pending_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_light_q  <= light;
      cnt_q         <= cnt_d;
      walk_q        <= walk_d;
      dont_walk_q   <= dont_walk_d;
      req_pending_q <= req_pending_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    walk_d        = walk_q;
    dont_walk_d   = dont_walk_q;
    req_pending_d = req_pending_q;
    fault_d       = fault_q;

    unique case (state_q)
      PED_IDLE: begin
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        if (red_entry && (req_pending_q || ped_req) && !fault_q) begin
          // A press coinciding with red entry goes straight to WALK and is
          // never latched.
          state_d       = PED_WALK;
          cnt_d         = WALK_LOAD;
          walk_d        = 1'b1;
          dont_walk_d   = 1'b0;
          req_pending_d = 1'b0;
        end else if (ped_req) begin
          req_pending_d = 1'b1;
        end
      end

      PED_WALK: begin
        if (!light_red) begin
          state_d     = PED_IDLE;
          cnt_d       = 4'd0;
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d     = PED_FLASH;
          cnt_d       = FLASH_LOAD;
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      PED_FLASH: begin
        walk_d = 1'b0;
        if (!light_red || (cnt_q == 4'd0)) begin
          state_d     = PED_IDLE;
          cnt_d       = 4'd0;
          dont_walk_d = 1'b1;
        end else begin
          cnt_d       = cnt_q - 4'd1;
          dont_walk_d = !dont_walk_q;
        end
      end

      default: begin
        state_d     = PED_IDLE;
        cnt_d       = 4'd0;
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
      end
    endcase

    // An illegal code overrides everything: latch the fault and drop to a
    // safe IDLE. red_entry is false for this code, so IDLE cannot start WALK.
    if (light == LIGHT_ILLEGAL) begin
      fault_d     = 1'b1;
      state_d     = PED_IDLE;
      cnt_d       = 4'd0;
      walk_d      = 1'b0;
      dont_walk_d = 1'b1;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign req_pending = req_pending_q;
  assign fault       = fault_q;

`ifdef PED_COUNTDOWN_EN
  localparam logic [4:0] FLASH_SPAN = 5'(FLASH_CYCLES);

  logic [3:0] countdown_q, countdown_d;
  logic [4:0] walk_remaining;

  // Derived from the next state so countdown is registered alongside the
  // lamps. WALK + FLASH can exceed 15, so the WALK figure saturates.
  always_comb begin
    walk_remaining = {1'b0, cnt_d} + 5'd1 + FLASH_SPAN;
    countdown_d    = 4'd0;
    unique case (state_d)
      PED_WALK:  countdown_d = (walk_remaining > 5'd15) ? 4'd15 : walk_remaining[3:0];
      PED_FLASH: countdown_d = cnt_d + 4'd1;
      default:   countdown_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      countdown_q <= 4'd0;
    end else begin
      countdown_q <= countdown_d;
    end
  end

  assign countdown = countdown_q;
`else
  assign countdown = 4'd0;
`endif

endmodule

// File: tb/tb_pedestrian_signal.sv
module tb_pedestrian_signal;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] light;
  logic       ped_req;
  logic       walk;
  logic       dont_walk;
  logic       req_pending;
  logic       fault;
  logic [3:0] countdown;

  int checks = 0;
  int errors = 0;

`ifdef PED_COUNTDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_GRN = 2'b01;
  localparam logic [1:0] L_YEL = 2'b10;
  localparam logic [1:0] L_ILL = 2'b11;

  // Expected per-cycle values for a full default crossing, starting with the
  // edge on which red entry is seen.
  logic       basic_walk [0:6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       basic_dw   [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] basic_cd   [0:6] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};

  always #5 clk = ~clk;

  pedestrian_signal #(
    .WALK_CYCLES (3),
    .FLASH_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .light      (light),
    .ped_req    (ped_req),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .fault      (fault),
    .countdown  (countdown)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    light   = L_GRN;
    ped_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    light   = L_RED;
    ped_req = 1'b0;
    #2;
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL reset_walk: got %b want 0", walk); end
    checks++; if (dont_walk !== 1'b1) begin errors++; $display("FAIL reset_dont_walk: got %b want 1", dont_walk); end
    checks++; if (req_pending !== 1'b0) begin errors++; $display("FAIL reset_req_pending: got %b want 0", req_pending); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++; if (countdown !== 4'd0) begin errors++; $display("FAIL reset_countdown: got %0d want 0", countdown); end
    tick();
    reset   = 1'b0;
    // Red held through release: a press now must only latch, not start WALK.
    ped_req = 1'b1;
    tick();
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL release_red_walk: got %b want 0", walk); end
    checks++; if (req_pending !== 1'b1) begin errors++; $display("FAIL release_red_pending: got %b want 1", req_pending); end
    ped_req = 1'b0;
    light   = L_GRN;
    tick();
    light = L_RED;
    tick();
    checks++; if (walk !== 1'b1) begin errors++; $display("FAIL pending_served_walk: got %b want 1", walk); end
    checks++; if (req_pending !== 1'b0) begin errors++; $display("FAIL pending_served_clear: got %b want 0", req_pending); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_basic_crossing;
    logic [3:0] exp_cd;
    do_reset();
    tick();
    ped_req = 1'b1;
    tick();
    checks++; if (req_pending !== 1'b1) begin errors++; $display("FAIL basic_latch: got %b want 1", req_pending); end
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL basic_green_walk: got %b want 0", walk); end
    ped_req = 1'b0;
    light   = L_RED;
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_cd = CD_EN ? basic_cd[i] : 4'd0;
      checks++; if (walk !== basic_walk[i]) begin errors++; $display("FAIL basic_walk[%0d]: got %b want %b", i, walk, basic_walk[i]); end
      checks++; if (dont_walk !== basic_dw[i]) begin errors++; $display("FAIL basic_dont_walk[%0d]: got %b want %b", i, dont_walk, basic_dw[i]); end
      checks++; if (req_pending !== 1'b0) begin errors++; $display("FAIL basic_pending[%0d]: got %b want 0", i, req_pending); end
      checks++; if (countdown !== exp_cd) begin errors++; $display("FAIL basic_countdown[%0d]: got %0d want %0d", i, countdown, exp_cd); end
    end
    $display("test_basic_crossing done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_no_request;
    do_reset();
    tick();
    light = L_RED;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (walk !== 1'b0) begin errors++; $display("FAIL noreq_walk[%0d]: got %b want 0", i, walk); end
      checks++; if (dont_walk !== 1'b1) begin errors++; $display("FAIL noreq_dont_walk[%0d]: got %b want 1", i, dont_walk); end
    end
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    checks++; if (req_pending !== 1'b1) begin errors++; $display("FAIL midred_latch: got %b want 1", req_pending); end
    tick();
    tick();
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL midred_walk: got %b want 0", walk); end
    light = L_GRN;
    tick();
    light = L_RED;
    tick();
    checks++; if (walk !== 1'b1) begin errors++; $display("FAIL next_red_walk: got %b want 1", walk); end
    checks++; if (req_pending !== 1'b0) begin errors++; $display("FAIL next_red_clear: got %b want 0", req_pending); end
    $display("test_no_request done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_same_cycle;
    do_reset();
    tick();
    light   = L_RED;
    ped_req = 1'b1;
    tick();
    checks++; if (walk !== 1'b1) begin errors++; $display("FAIL same_walk: got %b want 1", walk); end
    checks++; if (req_pending !== 1'b0) begin errors++; $display("FAIL same_pending: got %b want 0", req_pending); end
    // Button held throughout the crossing must be ignored.
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (req_pending !== 1'b0) begin errors++; $display("FAIL same_held_pending[%0d]: got %b want 0", i, req_pending); end
    end
    ped_req = 1'b0;
    checks++; if (walk !== 1'b0 || dont_walk !== 1'b1) begin errors++; $display("FAIL same_end: got walk=%b dont_walk=%b want 0/1", walk, dont_walk); end
    $display("test_same_cycle done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_abort;
    do_reset();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    light   = L_RED;
    tick();
    checks++; if (walk !== 1'b1) begin errors++; $display("FAIL abort_walk1: got %b want 1", walk); end
    tick();
    checks++; if (walk !== 1'b1) begin errors++; $display("FAIL abort_walk2: got %b want 1", walk); end
    light = L_GRN;
    tick();
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL abort_walk: got %b want 0", walk); end
    checks++; if (dont_walk !== 1'b1) begin errors++; $display("FAIL abort_dont_walk: got %b want 1", dont_walk); end
    checks++; if (countdown !== 4'd0) begin errors++; $display("FAIL abort_countdown: got %0d want 0", countdown); end
    light = L_RED;
    tick();
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL abort_not_restored: got %b want 0", walk); end
    // Abort from the first FLASH cycle: dont_walk stays 1 instead of toggling.
    do_reset();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    light   = L_RED;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (walk !== 1'b0 || dont_walk !== 1'b1) begin errors++; $display("FAIL flash1: got walk=%b dont_walk=%b want 0/1", walk, dont_walk); end
    light = L_YEL;
    tick();
    checks++; if (dont_walk !== 1'b1) begin errors++; $display("FAIL flash_abort_dont_walk: got %b want 1", dont_walk); end
    light = L_RED;
    tick();
    tick();
    checks++; if (dont_walk !== 1'b1 || walk !== 1'b0) begin errors++; $display("FAIL flash_abort_idle: got walk=%b dont_walk=%b want 0/1", walk, dont_walk); end
    $display("test_abort done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_fault;
    do_reset();
    light = L_ILL;
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b want 1", fault); end
    light = L_GRN;
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b want 1", fault); end
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    light   = L_RED;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (walk !== 1'b0) begin errors++; $display("FAIL fault_block_walk[%0d]: got %b want 0", i, walk); end
    end
    do_reset();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_cleared: got %b want 0", fault); end
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    light   = L_RED;
    tick();
    checks++; if (walk !== 1'b1) begin errors++; $display("FAIL fault_after_reset_walk: got %b want 1", walk); end
    light = L_ILL;
    tick();
    checks++; if (walk !== 1'b0 || dont_walk !== 1'b1 || fault !== 1'b1) begin errors++; $display("FAIL fault_in_walk: got walk=%b dont_walk=%b fault=%b want 0/1/1", walk, dont_walk, fault); end
    $display("test_fault done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_async_reset;
    do_reset();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    light   = L_RED;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (walk !== 1'b0 || dont_walk !== 1'b1) begin errors++; $display("FAIL async_reset: got walk=%b dont_walk=%b want 0/1", walk, dont_walk); end
    checks++; if (countdown !== 4'd0) begin errors++; $display("FAIL async_reset_countdown: got %0d want 0", countdown); end
    tick();
    reset   = 1'b0;
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    tick();
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL async_release_red: got %b want 0", walk); end
    $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    reset   = 1'b1;
    light   = L_GRN;
    ped_req = 1'b0;
    test_reset();
    test_basic_crossing();
    test_no_request();
    test_same_cycle();
    test_abort();
    test_fault();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pedestrian_signal.md
PEDESTRIAN_SIGNAL -- requirements
Module: pedestrian_signal

Interface
REQ-001 Parameter WALK_CYCLES, default 3, cycles of steady walk per crossing; legal range 1..15.
REQ-002 Parameter FLASH_CYCLES, default 2, cycles of flashing dont_walk after walk; legal range 1..15.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-high reset.
REQ-005 Port light, input, 2, vehicle light code from the upstream light controller: 00=Red, 01=Green, 10=Yellow, 11=illegal.
REQ-006 Port ped_req, input, 1, pedestrian button, level-sampled each clock.
REQ-007 Port walk, output, 1, walk lamp.
REQ-008 Port dont_walk, output, 1, don't-walk lamp.
REQ-009 Port req_pending, output, 1, latched request awaiting service.
REQ-010 Port fault, output, 1, sticky illegal-light-code flag.
REQ-011 Port countdown, output, 4, remaining crossing cycles.

Function
REQ-012 The block SHALL register light into prev_light each cycle; red_entry = (light==00) && (prev_light!=00).
REQ-013 FSM states SHALL be IDLE, WALK, FLASH; all outputs are registered.
REQ-014 IDLE: walk=0, dont_walk=1.
REQ-015 IDLE->WALK when red_entry && (req_pending || ped_req) && !fault; the counter loads WALK_CYCLES-1 and walk=1 from that edge.
REQ-016 WALK: walk=1, dont_walk=0 for exactly WALK_CYCLES cycles, then ->FLASH with the counter loaded to FLASH_CYCLES-1.
REQ-017 FLASH: walk=0, dont_walk=1 on the first FLASH cycle, toggling every cycle, for exactly FLASH_CYCLES cycles, then ->IDLE with dont_walk=1.
REQ-018 req_pending SHALL be set on any cycle with ped_req=1 in IDLE, cleared on the IDLE->WALK edge, and ignored/not set while in WALK or FLASH.
REQ-019 ped_req and red_entry in the same cycle SHALL start WALK directly, leaving req_pending=0.
REQ-020 Safety abort: in WALK or FLASH, sampled light!=00 SHALL force ->IDLE next edge (walk=0, dont_walk=1); an outstanding request is not restored.
REQ-021 A red_entry without a request SHALL leave the FSM in IDLE; a request arriving mid-red waits for the next red_entry.
REQ-022 light==11 on any cycle SHALL set fault, force IDLE, and block WALK until reset.
REQ-023 Counter SHALL be 4-bit, decrement-only, no wrap; transitions occur at counter==0.

Reset
REQ-024 On reset: state=IDLE, prev_light=00, counter=0, walk=0, dont_walk=1, req_pending=0, fault=0, countdown=0.
REQ-025 Reset mid-crossing SHALL take effect immediately and asynchronously, and a red already present at release SHALL NOT count as red_entry.

Configuration
REQ-026 With PED_COUNTDOWN_EN defined, countdown SHALL equal the remaining WALK cycles plus FLASH_CYCLES in WALK, the remaining FLASH cycles in FLASH, and 0 in IDLE.
REQ-027 Without PED_COUNTDOWN_EN, countdown SHALL be constant 0 and no countdown logic is synthesised.

Structure
REQ-028 The light codes (RED/GREEN/YELLOW/ILLEGAL) and the ped FSM state encoding SHALL live in shared package traffic_pkg, which the light controller also uses.
REQ-029 Single module; no sub-module (the edge detector is inline).

Verification
REQ-030 Press ped_req 1 cycle during Green, then light->00: walk=1 for 3 cycles, dont_walk toggles 1,0 over 2 cycles, then steady 1; req_pending 1->0 at walk start.
REQ-031 Red entry with no request: walk stays 0, dont_walk stays 1 for the entire red phase.
REQ-032 ped_req and red_entry in the same cycle: walk=1 next edge, req_pending never 1.
REQ-033 light->01 during the 2nd WALK cycle: next edge walk=0, dont_walk=1, state IDLE.
REQ-034 light=11 for 1 cycle: fault=1 persists; a later request plus red produces no walk until reset.
REQ-035 With PED_COUNTDOWN_EN: countdown reads 5,4,3,2,1 across the crossing, then 0; without it, countdown is 0 throughout.
